// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB from the latched IR,
// drives ALU controls and datapath strobes, and flags illegal opcodes and memory timeouts.
module mc_control_fsm #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Mem_Ready,
    input  logic        Branch_Flag,
    output logic [2:0]  ALUOp,
    output logic [1:0]  BorN,
    output logic        ALUSrcB,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        Reg_Write,
    output logic        RegDst,
    output logic        MemToReg,
    output logic [2:0]  State,
    output logic        Illegal,
    output logic        Bus_Error
);

    localparam int unsigned OP_W = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic             bus_err_q;

    logic [OP_W-1:0] op;
    logic is_r, is_imm, is_lw, is_sw, is_br, is_j, is_legal;
    logic wait_expired;
    logic unused_instr;

    // Opcode classification of the latched IR
    assign op       = Instr[31:26];
    assign is_r     = (op == 6'h00);
    assign is_imm   = (op[5:3] == 3'b001);
    assign is_lw    = (op == 6'h10);
    assign is_sw    = (op == 6'h11);
    assign is_br    = (op >= 6'h12) && (op <= 6'h15);
    assign is_j     = (op == 6'h16);
    assign is_legal = is_r | is_imm | is_lw | is_sw | is_br | is_j;

    assign unused_instr = ^Instr[25:3];

    // This waiting cycle is the WAIT_MAX-th one without Mem_Ready
    assign wait_expired = (wait_cnt == CNT_W'(WAIT_MAX - 1));

    assign State     = state;
    assign Illegal   = illegal_q;
    assign Bus_Error = bus_err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (Mem_Ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        bus_err_q <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    if (!is_legal) begin
                        illegal_q <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_lw || is_sw)     state <= S_MEM;
                    else if (is_r || is_imm) state <= S_WB;
                    else                     state <= S_FETCH;
                end
                S_MEM: begin
                    if (Mem_Ready) begin
                        wait_cnt <= '0;
                        state    <= is_lw ? S_WB : S_FETCH;
                    end else if (wait_expired) begin
                        bus_err_q <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes and ALU controls decoded from State/Instr; all forced low in reset
    always_comb begin
        ALUOp     = 3'd0;
        BorN      = 2'd0;
        ALUSrcB   = 1'b0;
        IR_Write  = 1'b0;
        PC_Write  = 1'b0;
        PC_Src    = 2'd0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        Reg_Write = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        if (!Reset) begin
            if (state != S_FETCH) begin
                if (is_r)                ALUOp = Instr[2:0];
                else if (is_imm)         ALUOp = op[2:0];
                else if (is_lw || is_sw) ALUOp = 3'd2;
                if (is_br) BorN = op[1:0];
                ALUSrcB = is_imm | is_lw | is_sw;
            end
            case (state)
                S_FETCH: begin
                    Mem_Read = 1'b1;
                    IR_Write = Mem_Ready;
                    PC_Write = Mem_Ready;
                end
                S_EXEC: begin
                    if (is_br) begin
                        PC_Write = Branch_Flag;
                        PC_Src   = 2'b01;
                    end else if (is_j) begin
                        PC_Write = 1'b1;
                        PC_Src   = 2'b10;
                    end
                end
                S_MEM: begin
                    Mem_Read  = is_lw;
                    Mem_Write = is_sw;
                end
                S_WB: begin
                    Reg_Write = 1'b1;
                    RegDst    = is_r;
                    MemToReg  = is_lw;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus random instruction streams,
// each cycle compared against an instruction-level reference model.
module tb_mc_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        Mem_Ready;
    logic        Branch_Flag;
    logic [2:0]  ALUOp;
    logic [1:0]  BorN;
    logic        ALUSrcB, IR_Write, PC_Write;
    logic [1:0]  PC_Src;
    logic        Mem_Read, Mem_Write, Reg_Write, RegDst, MemToReg;
    logic [2:0]  State;
    logic        Illegal, Bus_Error;

    mc_control_fsm #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Mem_Ready(Mem_Ready),
        .Branch_Flag(Branch_Flag), .ALUOp(ALUOp), .BorN(BorN), .ALUSrcB(ALUSrcB),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Src(PC_Src),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Reg_Write(Reg_Write),
        .RegDst(RegDst), .MemToReg(MemToReg), .State(State),
        .Illegal(Illegal), .Bus_Error(Bus_Error)
    );

    always #5 Clk = ~Clk;

    // Reference model: phase numbers are the architected State values
    localparam int FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4;
    localparam int C_R = 0, C_IMM = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_ILL = 6;

    int          m_phase = FETCH;
    int          m_wait  = 0;
    bit          m_ill   = 0;
    bit          m_be    = 0;
    logic [31:0] ir  = 32'h0;
    logic [31:0] nxt = 32'h0;
    int          checks = 0;
    int          errors = 0;

    function automatic int classify(input logic [31:0] i);
        int o;
        o = int'(i[31:26]);
        if (o == 0) return C_R;
        if (o >= 8 && o <= 15) return C_IMM;
        if (o == 16) return C_LW;
        if (o == 17) return C_SW;
        if (o >= 18 && o <= 21) return C_BR;
        if (o == 22) return C_J;
        return C_ILL;
    endfunction

    // One clock cycle: drive, compare mid-cycle, advance the model
    task automatic step(input bit rst, input bit mr, input bit bf, input string tag);
        logic [19:0] obs, exp_v;
        logic [2:0]  e_alu;
        logic [1:0]  e_born, e_pcsrc;
        logic        e_srcb, e_irw, e_pcw, e_mrd, e_mwr, e_rw, e_rd, e_m2r;
        int          c;
        Reset = rst; Mem_Ready = mr; Branch_Flag = bf; Instr = ir;
        @(negedge Clk);
        c = classify(ir);
        e_alu = 0; e_born = 0; e_pcsrc = 0; e_srcb = 0; e_irw = 0; e_pcw = 0;
        e_mrd = 0; e_mwr = 0; e_rw = 0; e_rd = 0; e_m2r = 0;
        if (!rst) begin
            if (m_phase != FETCH) begin
                case (c)
                    C_R:        e_alu = ir[2:0];
                    C_IMM:      e_alu = ir[28:26];
                    C_LW, C_SW: e_alu = 3'd2;
                    default:    e_alu = 3'd0;
                endcase
                if (c == C_BR) e_born = ir[27:26];
                e_srcb = (c == C_IMM || c == C_LW || c == C_SW);
            end
            if (m_phase == FETCH) begin e_mrd = 1; e_irw = mr; e_pcw = mr; end
            if (m_phase == EXEC && c == C_BR) begin e_pcw = bf; e_pcsrc = 2'b01; end
            if (m_phase == EXEC && c == C_J)  begin e_pcw = 1;  e_pcsrc = 2'b10; end
            if (m_phase == MEM) begin e_mrd = (c == C_LW); e_mwr = (c == C_SW); end
            if (m_phase == WB)  begin e_rw = 1; e_rd = (c == C_R); e_m2r = (c == C_LW); end
        end
        exp_v = {e_alu, e_born, e_srcb, e_irw, e_pcw, e_pcsrc, e_mrd, e_mwr, e_rw,
                 e_rd, e_m2r, 3'(m_phase), m_ill, m_be};
        obs   = {ALUOp, BorN, ALUSrcB, IR_Write, PC_Write, PC_Src, Mem_Read, Mem_Write,
                 Reg_Write, RegDst, MemToReg, State, Illegal, Bus_Error};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s phase=%0d instr=%h observed=%h expected=%h", tag, m_phase, ir, obs, exp_v);
        end
        if (rst) begin
            m_phase = FETCH; m_wait = 0; m_ill = 0; m_be = 0;
        end else begin
            case (m_phase)
                FETCH, MEM: begin
                    if (mr) begin
                        if (m_phase == FETCH) begin ir = nxt; m_phase = DECODE; end
                        else m_phase = (c == C_LW) ? WB : FETCH;
                        m_wait = 0;
                    end else if (m_wait + 1 == 15) begin
                        m_be = 1; m_wait = 0;
                    end else begin
                        m_wait++;
                    end
                end
                DECODE: begin
                    m_wait = 0;
                    if (c == C_ILL) begin m_ill = 1; m_phase = FETCH; end
                    else m_phase = EXEC;
                end
                EXEC: begin
                    m_wait = 0;
                    if (c == C_LW || c == C_SW) m_phase = MEM;
                    else if (c == C_R || c == C_IMM) m_phase = WB;
                    else m_phase = FETCH;
                end
                default: begin m_wait = 0; m_phase = FETCH; end
            endcase
        end
        @(posedge Clk);
        #1;
    endtask

    // Fetch and complete one instruction with the given memory stall lengths
    task automatic run_instr(input logic [31:0] i, input int fdel, input int mdel,
                             input bit bf, input string tag);
        int  fd, md;
        bit  started, done;
        fd = fdel; md = mdel; started = 0; done = 0;
        nxt = i;
        for (int n = 0; n < 100 && !done; n++) begin
            bit mr;
            mr = 1;
            if (m_phase == FETCH && fd > 0) begin mr = 0; fd--; end
            if (m_phase == MEM && md > 0)   begin mr = 0; md--; end
            step(0, mr, bf, tag);
            if (m_phase != FETCH) started = 1;
            else if (started) done = 1;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout observed=incomplete expected=complete", tag);
        end
    endtask

    initial begin
        logic [31:0] ri;
        int          ops[15];
        ops = '{0, 8, 9, 12, 15, 16, 17, 18, 19, 20, 21, 22, 63, 5, 30};
        Reset = 1; Mem_Ready = 0; Branch_Flag = 0; Instr = 0;
        @(posedge Clk); #1;
        step(1, 0, 0, "reset");
        step(1, 1, 1, "reset_strobes");

        run_instr({6'h00, 5'd1, 5'd2, 5'd3, 8'd0, 3'd2}, 0, 0, 0, "add");
        run_instr({6'h10, 5'd4, 5'd5, 16'h0010}, 0, 3, 0, "lw_stall");
        run_instr({6'h13, 5'd1, 5'd2, 16'h0004}, 0, 0, 1, "bne_taken");
        run_instr({6'h13, 5'd1, 5'd2, 16'h0004}, 0, 0, 0, "bne_not");
        run_instr({6'h16, 26'h0000123}, 0, 0, 0, "jump");
        run_instr({6'h0A, 5'd1, 5'd2, 16'hFFFF}, 0, 0, 0, "imm");
        run_instr({6'h00, 5'd1, 5'd2, 5'd3, 8'd0, 3'd7}, 16, 0, 0, "fetch_timeout");
        run_instr({6'h3F, 26'h0}, 0, 0, 0, "illegal");
        step(1, 0, 0, "reset_clear");
        run_instr({6'h11, 5'd1, 5'd2, 16'h0008}, 14, 0, 0, "ready_wins");
        run_instr({6'h11, 5'd1, 5'd2, 16'h0008}, 0, 20, 0, "mem_timeout");
        step(1, 0, 0, "reset_clear2");

        // Reset arriving mid-MEM of a store
        nxt = {6'h11, 5'd3, 5'd4, 16'h0002};
        for (int n = 0; n < 10 && m_phase != MEM; n++) step(0, 1, 0, "sw_to_mem");
        step(0, 0, 0, "sw_mem");
        step(1, 0, 0, "sw_reset");
        step(0, 0, 0, "after_reset");
        step(0, 1, 0, "after_reset_fetch");
        run_instr({6'h00, 26'h0}, 0, 0, 0, "after_reset_instr");

        for (int k = 0; k < 200; k++) begin
            int fdel, mdel;
            ri = $urandom;
            ri[31:26] = 6'(ops[$urandom_range(0, 14)]);
            fdel = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2);
            mdel = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            run_instr(ri, fdel, mdel, 1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 24) == 0) step(1, 1'($urandom_range(0, 1)), 0, "random_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
